i2c_eeprom_master: RTL
======================

# i2c_eeprom_master

Synthesizable I2C master transaction engine. It sits directly upstream of the AT24C64-style EEPROM on the SCL/SDA bus and downstream of the APB register front end. It turns one command (byte write or random read) into the complete I2C bit sequence: START, control byte, two address bytes, data, repeated START where needed, ACK/NACK, and STOP. Each transaction ends with a single done pulse, plus read data or an error flag.

## Interface
Parameters:
- CLK_DIV, 250 — pclk cycles per SCL quarter-period. SCL period = 4·CLK_DIV pclk. Legal range ≥2. A half-period must exceed the slave's 150 ns response delay.

Ports:
- pclk  in  1  — the single clock.
- prst  in  1  — reset. Synchronous, active-high.
- cmd_valid  in  1  — command request.
- cmd_ready  out  1  — high only in IDLE.
- cmd_rw  in  1  — 0 = byte write, 1 = random read.
- cmd_dev  in  3  — device select A2..A0.
- cmd_addr  in  13  — memory address.
- cmd_wdata  in  8  — write data.
- busy  out  1  — transaction in progress.
- done  out  1  — one-pclk pulse at the end of a transaction.
- rdata  out  8  — read byte. Valid from done until the next command is accepted.
- nack_err  out  1  — captured with done. 1 = a slave ACK was missing.
- scl_o  out  1  — 1 releases SCL high, 0 drives it low. No clock stretching is supported.
- sda_oe  out  1  — 1 pulls SDA low, 0 releases it. The pad is open-drain with a pull-up.
- sda_i  in  1  — sampled SDA. Synchronised by 2 flops inside this block.

## Operation
- Command accept: cmd_valid && cmd_ready. Capture rw, dev, addr and wdata. Clear nack_err. busy=1.
- Byte sequence:
  - ctrl_w = {4'b1010, dev, 1'b0}.
  - addr_h = {3'b000, addr[12:8]}.
  - addr_l = addr[7:0].
  - ctrl_r = {4'b1010, dev, 1'b1}.
- Write: START, ctrl_w, ACK, addr_h, ACK, addr_l, ACK, wdata, ACK, STOP.
- Read: START, ctrl_w, ACK, addr_h, ACK, addr_l, ACK, RSTART, ctrl_r, ACK, 8 data bits from the slave, master NACK (SDA released), STOP.
- State machine:
  - IDLE → START → TX_BYTE → RX_ACK.
  - From RX_ACK: next TX_BYTE, or RSTART (read, after addr_l), or RX_BYTE (after ctrl_r), or STOP (after last write byte).
  - RSTART → TX_BYTE(ctrl_r).
  - RX_BYTE → TX_NACK → STOP.
  - STOP → DONE → IDLE.
- Bit order is MSB first. A 2-bit byte index tracks the position in the sequence; a 3-bit bit counter counts down from 7.
- NACK: if ACK sampled as 1 in any RX_ACK, set nack_err, skip the remaining bytes and go to STOP. done still pulses. rdata keeps its previous value.
- Reset, including mid-transaction: the next edge forces state IDLE, scl_o=1, sda_oe=0, all counters 0. The bus is released immediately and no STOP is generated.
- cmd_valid is ignored while busy.

## Timing
- A quarter tick fires every CLK_DIV pclk. Every bus segment is 4 quarters, Q0..Q3.
- Data/ACK bit:
  - Q0–Q1: scl_o=0. SDA is updated at the start of Q0.
  - Q2–Q3: scl_o=1.
  - sda_i is sampled at the end of Q2.
- START (also taken from IDLE):
  - Q0–Q1: SDA released, scl_o=1.
  - Q2: sda_oe=1, scl high.
  - Q3: scl_o=0.
- RSTART:
  - Q0: scl low, SDA released.
  - Q1: scl_o=1.
  - Q2: sda_oe=1, scl high.
  - Q3: scl_o=0.
- STOP:
  - Q0: scl low, sda_oe=1.
  - Q1: scl_o=1.
  - Q2: release SDA (rising edge while SCL is high).
  - Q3: idle high.
- Total length, counted from the accept cycle:
  - Write = 4 + 4·36 + 4 = 152 quarters. done at accept + 152·CLK_DIV + 1.
  - Read = 4 + 3·36 + 4 + 36 + 36 + 4 = 192 quarters. done at accept + 192·CLK_DIV + 1.
- Reset values: cmd_ready=1, busy=0, done=0, rdata=0, nack_err=0, scl_o=1, sda_oe=0.
- cmd_ready returns high the cycle after done.
- A back-to-back command may be accepted in that cycle. The new START follows without extra idle quarters.

## Test plan
- Write with CLK_DIV=25, dev=0, addr=0x1ABC, wdata=0x5A against the EEPROM model. Required: all four ACKs seen; the model's memory[0x1ABC]=0x5A; done at accept+3801 cycles; nack_err=0.
- Read back addr 0x1ABC after the write. Required: SDA falls while SCL is high between addr_l and ctrl_r (repeated START); rdata=0x5A; master NACK bit is high; STOP seen; done at accept+4801 cycles.
- Address extremes: write 0x00 to addr 0x0000 and 0xFF to addr 0x1FFF, then read both back. Required: addr_h bytes on the wire are 0x00 and 0x1F; reads return 0x00 and 0xFF.
- No slave: SDA pulled up only, write command. Required: nack_err=1 after the ctrl_w ACK slot; STOP generated; done at accept + (4+36+4)·CLK_DIV + 1 cycles.
- prst asserted for 1 cycle during the addr_h bit 3 of a write. Required: next cycle scl_o=1, sda_oe=0, busy=0, cmd_ready=1; a following full write/read pair succeeds.
- cmd_valid held high continuously with two queued writes. Required: second accept in the cycle after the first done; the second command is not accepted while busy.

Source files
------------

// File: rtl/i2c_eeprom_master.sv
// I2C master for AT24C64-style EEPROMs: one byte write or random read per command,
// with START/RSTART/STOP framing, ACK checking and a single done pulse.
module i2c_eeprom_master #(
  parameter int CLK_DIV = 250
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [2:0]  cmd_dev,
  input  logic [12:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        nack_err,
  output logic        scl_o,
  output logic        sda_oe,
  input  logic        sda_i
);
  // state   | meaning
  // IDLE    | bus released, waiting for a command
  // START   | start condition (SDA falls while SCL high)
  // TX_BYTE | shifting one byte out, MSB first
  // RX_ACK  | SDA released, slave ACK sampled
  // RSTART  | repeated start before the read control byte
  // RX_BYTE | shifting the read byte in
  // TX_NACK | master NACK after the read byte
  // STOP    | stop condition (SDA rises while SCL high)
  // DONE    | one-cycle done pulse
  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP, DONE
  } state_t;

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  state_t           state, seg_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       q, byte_idx, nxt_idx;
  logic [2:0]       bit_cnt, dev_r;
  logic [7:0]       tx_sh, rx_sh, wdata_r, nxt_byte;
  logic [12:0]      addr_r;
  logic             rw_r, load_tx;
  logic             sda_meta, sda_s, sda_smp;

  // {scl_o, sda_oe} for quarter qq of a segment
  function automatic logic [1:0] seg_out(input state_t st, input logic [1:0] qq, input logic data_oe);
    logic [1:0] r;
    r = 2'b10;
    case (st)
      START:   r = (qq == 2'd3) ? 2'b01 : (qq == 2'd2) ? 2'b11 : 2'b10;
      RSTART:  r = (qq == 2'd0) ? 2'b00 : (qq == 2'd1) ? 2'b10 : (qq == 2'd2) ? 2'b11 : 2'b01;
      STOP:    r = (qq == 2'd0) ? 2'b01 : (qq == 2'd1) ? 2'b11 : 2'b10;
      TX_BYTE: r = {qq[1], data_oe};
      RX_ACK, RX_BYTE, TX_NACK: r = {qq[1], 1'b0};
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {4'b1010, dev_r, 1'b0};
      2'd1:    b = {3'b000, addr_r[12:8]};
      2'd2:    b = addr_r[7:0];
      default: b = rw_r ? {4'b1010, dev_r, 1'b1} : wdata_r;
    endcase
    return b;
  endfunction

  always_comb begin
    nxt_idx  = (state == START) ? 2'd0 : byte_idx + 2'd1;
    nxt_byte = byte_sel(nxt_idx);
    seg_nxt  = state;
    case (state)
      START:   seg_nxt = TX_BYTE;
      TX_BYTE: seg_nxt = (bit_cnt == 3'd0) ? RX_ACK : TX_BYTE;
      RX_ACK: begin
        if (sda_smp)                seg_nxt = STOP;
        else if (byte_idx == 2'd2)  seg_nxt = rw_r ? RSTART : TX_BYTE;
        else if (byte_idx == 2'd3)  seg_nxt = rw_r ? RX_BYTE : STOP;
        else                        seg_nxt = TX_BYTE;
      end
      RSTART:  seg_nxt = TX_BYTE;
      RX_BYTE: seg_nxt = (bit_cnt == 3'd0) ? TX_NACK : RX_BYTE;
      TX_NACK: seg_nxt = STOP;
      STOP:    seg_nxt = DONE;
      default: seg_nxt = state;
    endcase
    load_tx = (seg_nxt == TX_BYTE) && (state != TX_BYTE);
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      sda_meta <= 1'b1;
      sda_s    <= 1'b1;
    end else begin
      sda_meta <= sda_i;
      sda_s    <= sda_meta;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      q         <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      sda_smp   <= 1'b1;
      rw_r      <= 1'b0;
      dev_r     <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      nack_err  <= 1'b0;
      scl_o     <= 1'b1;
      sda_oe    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          rw_r      <= cmd_rw;
          dev_r     <= cmd_dev;
          addr_r    <= cmd_addr;
          wdata_r   <= cmd_wdata;
          nack_err  <= 1'b0;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= START;
          div_cnt   <= DIV_LOAD;
          q         <= '0;
          {scl_o, sda_oe} <= seg_out(START, 2'd0, 1'b0);
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_LOAD;
            if (q == 2'd2) begin
              sda_smp <= sda_s;
              if (state == RX_BYTE) rx_sh <= {rx_sh[6:0], sda_s};
            end
            if (q != 2'd3) begin
              q <= q + 2'd1;
              {scl_o, sda_oe} <= seg_out(state, q + 2'd1, ~tx_sh[7]);
            end else begin
              // segment boundary: pick the next segment and present its Q0 levels
              q     <= '0;
              state <= seg_nxt;
              {scl_o, sda_oe} <= seg_out(seg_nxt, 2'd0, load_tx ? ~nxt_byte[7] : ~tx_sh[6]);
              if (load_tx) begin
                tx_sh    <= nxt_byte;
                byte_idx <= nxt_idx;
                bit_cnt  <= 3'd7;
              end else if (seg_nxt == RX_BYTE && state != RX_BYTE) begin
                bit_cnt <= 3'd7;
              end else if (state == TX_BYTE || state == RX_BYTE) begin
                bit_cnt <= bit_cnt - 3'd1;
                tx_sh   <= {tx_sh[6:0], 1'b0};
              end
              if (state == RX_ACK && sda_smp) nack_err <= 1'b1;
              if (state == RX_BYTE && bit_cnt == 3'd0) rdata <= rx_sh;
              if (seg_nxt == DONE) done <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
